mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Bus master for the 4 KiB byte-wide memory port: clk, we, 12-bit addr, 8-bit in, 8-bit out.
- Sits on the initiator side and drives we/addr/in itself.
- Performs block copy (memory to memory) or block fill (constant to memory) on a single start pulse, then reports completion.
- Used for bulk transfers such as font/program loading, screen clear and register-file save/restore, so the CPU core does not issue byte writes one by one.

Parameters:
- ADDR_W, 12, memory address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, memory data width.
- READ_LATENCY, 1, clock cycles from address presented with we=0 until read data is valid on mem_rdata.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch request, sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill; sampled with start.
- src  in  ADDR_W  copy source base; sampled with start; ignored in fill.
- dst  in  ADDR_W  destination base; sampled with start.
- len  in  ADDR_W+1  byte count, 0..4096; sampled with start.
- fill_val  in  DATA_W  fill byte; sampled with start.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle completion pulse.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data, driven to memory "in".
- mem_rdata  in  DATA_W  memory read data, taken from memory "out".

Behaviour:
- Reset: all outputs registered. rst_n low forces, immediately and asynchronously, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE, counters=0.
- Reset mid-transfer abandons the transfer. Bytes already written stay written. No done pulse is issued.
- States: IDLE, RD, WAIT, WR, FILL, FIN.
- IDLE, start=1, len=0: go to FIN. No memory access occurs.
- IDLE, start=1, len!=0: latch src, dst, len and fill_val; set busy=1.
  - Copy: go to RD.
  - Fill: go to FILL.
- start while busy=1 or in FIN is ignored; inputs are not re-sampled.
- RD (1 cycle): mem_we=0, mem_addr=src_ptr. Then go to WAIT.
- WAIT (READ_LATENCY cycles): mem_we=0. On the final WAIT edge, capture mem_rdata into mem_wdata, set mem_addr=dst_ptr and mem_we=1, and go to WR.
- WR (1 cycle): the memory commits the write at the next edge.
  - On that edge: src_ptr+1, dst_ptr+1, remaining-1.
  - If remaining becomes 0, go to FIN with mem_we=0; otherwise go to RD.
- Copy throughput: 2+READ_LATENCY cycles per byte, i.e. 3 cycles at default.
- FILL: each cycle mem_we=1, mem_addr=dst_ptr, mem_wdata=fill_val.
  - Each edge: dst_ptr+1, remaining-1.
  - The last byte's edge goes to FIN with mem_we=0. Throughput is 1 byte/cycle.
- FIN (1 cycle): done=1, busy=0, mem_we=0. Then go to IDLE. done is never high for more than one cycle.
- Latency from start edge to done: len*(2+READ_LATENCY)+1 cycles for copy, len+1 for fill, 1 for len=0.
- Pointers are ADDR_W bits and wrap from 0xFFF to 0x000 silently. len=4096 touches every address exactly once.
- Overlap: copy is strictly ascending and byte-serial; each byte is read before the write that follows it.
  - dst in (src, src+len) therefore propagates the source pattern (e.g. dst=src+1 replicates byte[src]).
  - dst=src rewrites identical data.
- mem_we is never high in IDLE, RD, WAIT or FIN.
- mem_addr holds its last value when idle.

Test Plan:
- Fill: mode=1, dst=0x000, len=4, fill_val=0xA1 -> mem_we high exactly 4 cycles at addr 0x000..0x003; done 5 cycles after start; readback gives A1 x4, 0x004 untouched.
- Copy: preload 0x200..0x202 = B1,B2,B3; mode=0, src=0x200, dst=0x600, len=3 -> writes at 0x600/0x601/0x602 with data B1/B2/B3, one write every 3 cycles; done 10 cycles after start; busy low with done.
- Wrap-around: fill dst=0xFFE, len=4, fill_val=0xD3 -> writes at 0xFFE, 0xFFF, 0x000, 0x001; no other address written.
- Zero-length and ignored start: len=0 -> done the next cycle, mem_we never asserted. A second start pulse mid-copy changes no address or data sequence.
- Overlap: 0x400=C1, copy src=0x400, dst=0x401, len=3 -> 0x401..0x403 all read back C1.
- Reset mid-op: assert rst_n=0 during the 2nd WR of a 4-byte copy -> mem_we=0 and busy=0 without waiting for a clock edge; no done pulse; only the first byte is written. After release, a new fill completes normally.

Source files
------------

// File: rtl/mem_copy_engine_if.sv
// Control and memory-bus bundle for the block copy/fill engine.
// The master modport is the engine's view; the slave modport is the CPU/memory side.
interface mem_copy_engine_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] fill_val;
    logic              busy;
    logic              done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  start, mode, src, dst, len, fill_val, mem_rdata,
        output busy, done, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output start, mode, src, dst, len, fill_val, mem_rdata,
        input  busy, done, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy / block fill bus master for a byte-wide synchronous memory.
// All outputs are registered; next values are computed in a single combinational process.
module mem_copy_engine #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_copy_engine_if.master bus
);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FILL, FIN} state_t;

    state_t            state, state_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [ADDR_W-1:0] src_ptr, src_n;
    logic [ADDR_W-1:0] dst_ptr, dst_n;
    logic [ADDR_W:0]   rem, rem_n;
    logic [LAT_W-1:0]  wcnt, wcnt_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            src_ptr <= '0;
            dst_ptr <= '0;
            rem     <= '0;
            wcnt    <= '0;
        end else begin
            state   <= state_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            src_ptr <= src_n;
            dst_ptr <= dst_n;
            rem     <= rem_n;
            wcnt    <= wcnt_n;
        end
    end

    // Outputs are the values they will hold in the cycle after this edge.
    always_comb begin
        state_n = state;
        busy_n  = busy_q;
        done_n  = 1'b0;
        we_n    = 1'b0;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        src_n   = src_ptr;
        dst_n   = dst_ptr;
        rem_n   = rem;
        wcnt_n  = wcnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        state_n = FIN;
                        done_n  = 1'b1;
                    end else begin
                        busy_n  = 1'b1;
                        src_n   = bus.src;
                        dst_n   = bus.dst;
                        rem_n   = bus.len;
                        wdata_n = bus.fill_val;
                        if (bus.mode) begin
                            state_n = FILL;
                            we_n    = 1'b1;
                            addr_n  = bus.dst;
                        end else begin
                            state_n = RD;
                            addr_n  = bus.src;
                        end
                    end
                end
            end
            RD: begin
                state_n = WAIT;
                wcnt_n  = LAT_W'(READ_LATENCY - 1);
            end
            WAIT: begin
                if (wcnt == '0) begin
                    state_n = WR;
                    we_n    = 1'b1;
                    addr_n  = dst_ptr;
                    wdata_n = bus.mem_rdata;
                end else begin
                    wcnt_n = wcnt - LAT_W'(1);
                end
            end
            WR: begin
                src_n = src_ptr + PTR_ONE;
                dst_n = dst_ptr + PTR_ONE;
                rem_n = rem - REM_ONE;
                if (rem == REM_ONE) begin
                    state_n = FIN;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    state_n = RD;
                    addr_n  = src_ptr + PTR_ONE;
                end
            end
            // Address and data for the current byte are already on the bus.
            FILL: begin
                dst_n = dst_ptr + PTR_ONE;
                rem_n = rem - REM_ONE;
                if (rem == REM_ONE) begin
                    state_n = FIN;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    we_n   = 1'b1;
                    addr_n = dst_ptr + PTR_ONE;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: 4 KiB memory model, write scoreboard, latency and readback checks.
// Expected writes come from a shadow memory updated byte-serially as each transfer is launched.
module tb_mem_copy_engine;
    logic clk;
    logic rst_n;

    mem_copy_engine_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    mem_copy_engine #(.ADDR_W(12), .DATA_W(8), .READ_LATENCY(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  mem    [4096];
    logic [7:0]  refMem [4096];
    logic [19:0] wrQ [$];
    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    int expGap  = 0;
    int prevWrCyc = 0;
    bit havePrev  = 0;
    logic prevDone = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every observed write is popped from the scoreboard and compared.
    always @(negedge clk) begin
        logic [19:0] e;
        if (bus.mem_we) begin
            if (wrQ.size() == 0) begin
                checkOutput("spuriousWrite", {20'h0, bus.mem_addr}, 32'hDEAD_BEEF);
            end else begin
                e = wrQ.pop_front();
                checkOutput("wrAddr", 32'(bus.mem_addr), 32'(e[19:8]));
                checkOutput("wrData", 32'(bus.mem_wdata), 32'(e[7:0]));
            end
            if (havePrev && expGap != 0) checkOutput("wrGap", 32'(cyc - prevWrCyc), 32'(expGap));
            prevWrCyc = cyc;
            havePrev  = 1;
        end
        if (bus.done) begin
            checkOutput("doneWidth", 32'(prevDone), 32'd0);
            checkOutput("weAtDone", 32'(bus.mem_we), 32'd0);
        end
        prevDone = bus.done;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input string tag, input logic m, input logic [11:0] s,
                                 input logic [11:0] d, input logic [12:0] l, input logic [7:0] fv);
        int expLat;
        int cnt;
        logic [7:0]  b;
        logic [11:0] a;
        expLat = (l == 0) ? 1 : (m ? int'(l) + 1 : int'(l) * 3 + 1);
        for (int i = 0; i < int'(l); i++) begin
            b = m ? fv : refMem[s + 12'(i)];
            a = d + 12'(i);
            refMem[a] = b;
            wrQ.push_back({a, b});
        end
        expGap   = m ? 1 : 3;
        havePrev = 0;
        bus.mode = m; bus.src = s; bus.dst = d; bus.len = l; bus.fill_val = fv;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 1;
        while (!bus.done && cnt < 20000) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput({tag, "_latency"}, 32'(cnt), 32'(expLat));
        checkOutput({tag, "_busyAtDone"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_donePulse"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_sbDrained"}, 32'(wrQ.size()), 32'd0);
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] v);
        mem[a]    = v;
        refMem[a] = v;
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 8'h00;
            refMem[i] = 8'h00;
        end
        rst_n = 1'b0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0; bus.fill_val = '0;
        #2;
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        checkOutput("rstDone", 32'(bus.done), 32'd0);
        checkOutput("rstWe", 32'(bus.mem_we), 32'd0);
        checkOutput("rstAddr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rstWdata", 32'(bus.mem_wdata), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus("fill", 1'b1, 12'h000, 12'h000, 13'd4, 8'hA1);
        for (int i = 0; i < 4; i++) checkOutput("fillMem", 32'(mem[i]), 32'hA1);
        checkOutput("fillUntouched", 32'(mem[4]), 32'h00);

        preload(12'h200, 8'hB1); preload(12'h201, 8'hB2); preload(12'h202, 8'hB3);
        applyStimulus("copy", 1'b0, 12'h200, 12'h600, 13'd3, 8'h00);
        checkOutput("copyMem0", 32'(mem[12'h600]), 32'hB1);
        checkOutput("copyMem1", 32'(mem[12'h601]), 32'hB2);
        checkOutput("copyMem2", 32'(mem[12'h602]), 32'hB3);

        applyStimulus("wrap", 1'b1, 12'h000, 12'hFFE, 13'd4, 8'hD3);
        checkOutput("wrapFFF", 32'(mem[12'hFFF]), 32'hD3);
        checkOutput("wrap001", 32'(mem[12'h001]), 32'hD3);
        checkOutput("wrapFFD", 32'(mem[12'hFFD]), 32'h00);
        checkOutput("wrap002", 32'(mem[12'h002]), 32'hA1);

        applyStimulus("zeroLen", 1'b0, 12'h123, 12'h456, 13'd0, 8'h77);

        for (int i = 0; i < 4; i++) preload(12'h210 + 12'(i), 8'hF1 + 8'(i));
        fork
            applyStimulus("ignStart", 1'b0, 12'h210, 12'h610, 13'd4, 8'h00);
            begin
                repeat (4) @(negedge clk);
                bus.start = 1'b1; bus.mode = 1'b1; bus.dst = 12'h700; bus.len = 13'd5; bus.fill_val = 8'h99;
                @(negedge clk);
                bus.start = 1'b0;
            end
        join
        checkOutput("ignStartMem", 32'(mem[12'h613]), 32'hF4);
        checkOutput("ignStart700", 32'(mem[12'h700]), 32'h00);

        preload(12'h400, 8'hC1);
        applyStimulus("overlap", 1'b0, 12'h400, 12'h401, 13'd3, 8'h00);
        for (int i = 1; i < 4; i++) checkOutput("overlapMem", 32'(mem[12'h400 + 12'(i)]), 32'hC1);

        // Abandon a copy during its second write cycle.
        for (int i = 0; i < 4; i++) preload(12'h300 + 12'(i), 8'hE1 + 8'(i));
        wrQ.push_back({12'h500, 8'hE1});
        wrQ.push_back({12'h501, 8'hE2});
        expGap = 3; havePrev = 0;
        bus.mode = 1'b0; bus.src = 12'h300; bus.dst = 12'h500; bus.len = 13'd4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            #1;
            cnt++;
        end while (wrQ.size() != 0 && cnt < 50);
        checkOutput("rstMidReachedWr2", 32'(wrQ.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("rstMidWe", 32'(bus.mem_we), 32'd0);
        checkOutput("rstMidBusy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rstMidNoDone", 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        refMem[12'h500] = 8'hE1;
        checkOutput("rstMidByte0", 32'(mem[12'h500]), 32'hE1);
        checkOutput("rstMidByte1", 32'(mem[12'h501]), 32'h00);
        @(negedge clk);
        checkOutput("rstMidNoDoneAfter", 32'(bus.done), 32'd0);

        applyStimulus("postRst", 1'b1, 12'h000, 12'h800, 13'd3, 8'h5A);
        for (int i = 0; i < 3; i++) checkOutput("postRstMem", 32'(mem[12'h800 + 12'(i)]), 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
